// File: rtl/hvgen_prm_if.sv
// Video timing bus between the core-side logic and the raster generator.
// The master side drives the pixel enable, sync offsets and colour; the slave side returns timing.
interface hvgen_prm_if #(
  parameter int unsigned CW   = 9,
  parameter int unsigned RGBW = 8
);
  logic            CE;
  logic [4:0]      HOFFS;
  logic [4:0]      VOFFS;
  logic [RGBW-1:0] iRGB;
  logic [CW-1:0]   HPOS;
  logic [CW-1:0]   VPOS;
  logic [RGBW-1:0] oRGB;
  logic            HBLK;
  logic            VBLK;
  logic            HSYN;
  logic            VSYN;
  logic            LINE_END;
  logic            FRAME_END;
  logic [7:0]      FCNT;

  modport master (
    output CE, HOFFS, VOFFS, iRGB,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, LINE_END, FRAME_END, FCNT
  );

  modport slave (
    input  CE, HOFFS, VOFFS, iRGB,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, LINE_END, FRAME_END, FCNT
  );
endinterface

// File: rtl/hvgen_prm.sv
// Raster timing generator: pixel/line counters, blanking, offset-adjustable H/V sync,
// line/frame strobes, frame counter and blank-gated colour output.
module hvgen_prm #(
  parameter int unsigned CW      = 9,
  parameter int unsigned RGBW    = 8,
  parameter int unsigned HTOTAL  = 396,
  parameter int unsigned HACT_B  = 0,
  parameter int unsigned HACT_E  = 257,
  parameter int unsigned HS_BASE = 288,
  parameter int unsigned HS_STEP = 2,
  parameter int unsigned HS_W    = 32,
  parameter int unsigned VTOTAL  = 256,
  parameter int unsigned VACT_B  = 15,
  parameter int unsigned VACT_E  = 239,
  parameter int unsigned VS_BASE = 240,
  parameter int unsigned VS_STEP = 4,
  parameter int unsigned VS_W    = 4
) (
  input  logic       PCLK,
  input  logic       RESET_N,
  hvgen_prm_if.slave bus
);

  localparam int unsigned SW = CW + 8;
  typedef logic [CW-1:0]        cnt_t;
  typedef logic signed [SW-1:0] pos_t;

  localparam cnt_t HLast  = cnt_t'(HTOTAL - 1);
  localparam cnt_t VLast  = cnt_t'(VTOTAL - 1);
  localparam cnt_t HActB  = cnt_t'(HACT_B);
  localparam cnt_t HActE  = cnt_t'(HACT_E);
  localparam cnt_t VActB  = cnt_t'(VACT_B);
  localparam cnt_t VActE  = cnt_t'(VACT_E);
  localparam pos_t HTotS  = pos_t'(HTOTAL);
  localparam pos_t VTotS  = pos_t'(VTOTAL);
  localparam pos_t HBaseS = pos_t'(HS_BASE);
  localparam pos_t VBaseS = pos_t'(VS_BASE);
  localparam pos_t HStepS = pos_t'(HS_STEP);
  localparam pos_t VStepS = pos_t'(VS_STEP);
  localparam pos_t HWidS  = pos_t'(HS_W);
  localparam pos_t VWidS  = pos_t'(VS_W);

  cnt_t              hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic              hblk_q, hblk_d, vblk_q, vblk_d;
  logic              hsyn_q, hsyn_d, vsyn_q, vsyn_d;
  logic              line_end_q, line_end_d, frame_end_q, frame_end_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [RGBW-1:0]   rgb_q, rgb_d;
  logic signed [4:0] hoffs_q, hoffs_d, voffs_q, voffs_d;

  logic line_wrap, frame_wrap;
  pos_t hs_sum, hs_b, hs_e, vs_sum, vs_b, vs_e, hpos_w, vpos_w;

  assign line_wrap  = (hcnt_q == HLast);
  assign frame_wrap = line_wrap && (vcnt_q == VLast);
  assign hpos_w     = pos_t'(hcnt_q);
  assign vpos_w     = pos_t'(vcnt_q);

  // Sync positions follow the shadow offsets; signed remainder is folded back into [0, total-1].
  always_comb begin
    hs_sum = HBaseS + pos_t'(hoffs_q) * HStepS;
    hs_b   = hs_sum % HTotS;
    if (hs_b < 0) hs_b = hs_b + HTotS;
    hs_e   = (hs_b + HWidS) % HTotS;
    vs_sum = VBaseS + pos_t'(voffs_q) * VStepS;
    vs_b   = vs_sum % VTotS;
    if (vs_b < 0) vs_b = vs_b + VTotS;
    vs_e   = (vs_b + VWidS) % VTotS;
  end

  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    hblk_d      = hblk_q;
    vblk_d      = vblk_q;
    hsyn_d      = hsyn_q;
    vsyn_d      = vsyn_q;
    line_end_d  = 1'b0;
    frame_end_d = 1'b0;
    fcnt_d      = fcnt_q;
    rgb_d       = rgb_q;
    hoffs_d     = hoffs_q;
    voffs_d     = voffs_q;
    if (bus.CE) begin
      hcnt_d      = line_wrap ? '0 : hcnt_q + cnt_t'(1);
      line_end_d  = line_wrap;
      frame_end_d = frame_wrap;
      rgb_d       = (hblk_q || vblk_q) ? '0 : bus.iRGB;
      if (hcnt_q == HActB)      hblk_d = 1'b0;
      else if (hcnt_q == HActE) hblk_d = 1'b1;
      // Start is tested first so a coincident end match leaves sync asserted.
      if (hpos_w == hs_b)      hsyn_d = 1'b0;
      else if (hpos_w == hs_e) hsyn_d = 1'b1;
      if (line_wrap) begin
        vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + cnt_t'(1);
        if (vcnt_q == VActB)      vblk_d = 1'b0;
        else if (vcnt_q == VActE) vblk_d = 1'b1;
        if (vpos_w == vs_b)      vsyn_d = 1'b0;
        else if (vpos_w == vs_e) vsyn_d = 1'b1;
      end
      if (frame_wrap) begin
        fcnt_d  = fcnt_q + 8'd1;
        hoffs_d = bus.HOFFS;
        voffs_d = bus.VOFFS;
      end
    end
  end

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hblk_q      <= 1'b1;
      vblk_q      <= 1'b1;
      hsyn_q      <= 1'b1;
      vsyn_q      <= 1'b1;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      fcnt_q      <= '0;
      rgb_q       <= '0;
      hoffs_q     <= '0;
      voffs_q     <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hblk_q      <= hblk_d;
      vblk_q      <= vblk_d;
      hsyn_q      <= hsyn_d;
      vsyn_q      <= vsyn_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      fcnt_q      <= fcnt_d;
      rgb_q       <= rgb_d;
      hoffs_q     <= hoffs_d;
      voffs_q     <= voffs_d;
    end
  end

  assign bus.HPOS      = hcnt_q;
  assign bus.VPOS      = vcnt_q;
  assign bus.oRGB      = rgb_q;
  assign bus.HBLK      = hblk_q;
  assign bus.VBLK      = vblk_q;
  assign bus.HSYN      = hsyn_q;
  assign bus.VSYN      = vsyn_q;
  assign bus.LINE_END  = line_end_q;
  assign bus.FRAME_END = frame_end_q;
  assign bus.FCNT      = fcnt_q;

endmodule

// File: tb/tb_hvgen_prm.sv
// Directed bench for hvgen_prm on a reduced raster (16 x 8) so many frames fit in a short run.
module tb_hvgen_prm;

  logic PCLK;
  logic RESET_N;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fe_seen  = 0;

  hvgen_prm_if #(.CW(5), .RGBW(8)) bus ();

  hvgen_prm #(
    .CW(5), .RGBW(8),
    .HTOTAL(16), .HACT_B(0), .HACT_E(10), .HS_BASE(12), .HS_STEP(1), .HS_W(3),
    .VTOTAL(8),  .VACT_B(1), .VACT_E(6),  .VS_BASE(6),  .VS_STEP(1), .VS_W(2)
  ) dut (
    .PCLK    (PCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Bench-side frame count, the reference for FCNT.
  always @(negedge PCLK) begin
    if (!RESET_N) fe_seen = 0;
    else if (bus.FRAME_END) fe_seen = fe_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    bus.iRGB = {3'b100, bus.HPOS};
  endtask

  logic [7:0] vb_mask, vs_mask, rgb5, fcnt0;
  int         fe_cnt, fe_idx, le_cnt, hs_fall, hs_low, hb_low, rgb_cnt;

  // Caller sits on the last pixel of a frame; this walks the whole next frame.
  task automatic scan_frame(input int chg_line, input logic [4:0] nh, input logic [4:0] nv);
    int   h, v;
    logic prev_hs;
    prev_hs = 1'b0;
    vb_mask = '0; vs_mask = '0; rgb5 = '0; fcnt0 = '0;
    fe_cnt = 0; fe_idx = -1; le_cnt = 0; hs_fall = 99; hs_low = 0; hb_low = 0; rgb_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      h = int'(bus.HPOS);
      v = int'(bus.VPOS);
      if (i == 0) fcnt0 = bus.FCNT;
      if (h == 0 && v < 8) begin
        vb_mask[v] = bus.VBLK;
        vs_mask[v] = bus.VSYN;
      end
      if (bus.FRAME_END) begin
        fe_cnt++;
        fe_idx = i;
      end
      if (bus.LINE_END) le_cnt++;
      if (v == 5) begin
        if (!bus.HSYN) hs_low++;
        if (!bus.HSYN && prev_hs && hs_fall == 99) hs_fall = h;
        if (!bus.HBLK) hb_low++;
        if (bus.oRGB != 8'h00) rgb_cnt++;
        if (h == 5) rgb5 = bus.oRGB;
      end
      prev_hs = bus.HSYN;
      if (h == 0 && v == chg_line) begin
        bus.HOFFS = nh;
        bus.VOFFS = nv;
      end
    end
  endtask

  task automatic frame_case(input string nm, input int chg, input logic [4:0] nh,
                            input logic [4:0] nv, input int exp_fcnt, input int exp_vs,
                            input int exp_fall);
    scan_frame(chg, nh, nv);
    check_eq({nm, ".fcnt"},    32'(fcnt0),   32'(exp_fcnt));
    check_eq({nm, ".vblk"},    32'(vb_mask), 32'h83);
    check_eq({nm, ".vsyn"},    32'(vs_mask), 32'(exp_vs));
    check_eq({nm, ".fe_cnt"},  32'(fe_cnt),  32'd1);
    check_eq({nm, ".fe_idx"},  32'(fe_idx),  32'd0);
    check_eq({nm, ".le_cnt"},  32'(le_cnt),  32'd8);
    check_eq({nm, ".hs_fall"}, 32'(hs_fall), 32'(exp_fall));
    check_eq({nm, ".hs_low"},  32'(hs_low),  32'd3);
    check_eq({nm, ".hb_low"},  32'(hb_low),  32'd10);
    check_eq({nm, ".rgb_cnt"}, 32'(rgb_cnt), 32'd10);
    check_eq({nm, ".rgb5"},    32'(rgb5),    32'h84);
  endtask

  initial begin
    int   guard, ret1, ret2, prev_h, run, run_max, le_n;
    logic found;

    RESET_N   = 1'b0;
    bus.CE    = 1'b1;
    bus.HOFFS = 5'd0;
    bus.VOFFS = 5'd0;
    bus.iRGB  = 8'h80;
    repeat (3) @(posedge PCLK);
    #1 RESET_N = 1'b1;

    // Run into the active part of line 0, then reset asynchronously between edges.
    repeat (9) tick();
    check_eq("pre_rst.hpos", 32'(bus.HPOS), 32'd9);
    check_eq("pre_rst.hblk", 32'(bus.HBLK), 32'd0);
    #3 RESET_N = 1'b0;
    #1;
    check_eq("rst.hpos",  32'(bus.HPOS),      32'd0);
    check_eq("rst.vpos",  32'(bus.VPOS),      32'd0);
    check_eq("rst.hblk",  32'(bus.HBLK),      32'd1);
    check_eq("rst.vblk",  32'(bus.VBLK),      32'd1);
    check_eq("rst.hsyn",  32'(bus.HSYN),      32'd1);
    check_eq("rst.vsyn",  32'(bus.VSYN),      32'd1);
    check_eq("rst.orgb",  32'(bus.oRGB),      32'd0);
    check_eq("rst.le",    32'(bus.LINE_END),  32'd0);
    check_eq("rst.fe",    32'(bus.FRAME_END), 32'd0);
    check_eq("rst.fcnt",  32'(bus.FCNT),      32'd0);
    @(posedge PCLK);
    @(posedge PCLK);
    #1 RESET_N = 1'b1;
    tick();
    check_eq("rel.hpos", 32'(bus.HPOS), 32'd1);
    check_eq("rel.vpos", 32'(bus.VPOS), 32'd0);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (bus.HPOS == 5'd15 && bus.VPOS == 5'd7) found = 1'b1;
      else tick();
    end
    check_eq("sync", 32'(found), 32'd1);

    // HOFFS/VOFFS change mid-frame; each takes effect only from the following frame.
    frame_case("f1", 4,  5'd5,     5'd0,     1, 32'h7E, 13);
    frame_case("f2", 4,  5'd5,     5'd2,     2, 32'h7E, 2);
    frame_case("f3", 4,  5'd2,     5'd2,     3, 32'hF8, 2);
    frame_case("f4", 4,  5'b10001, 5'b10111, 4, 32'hF9, 15);
    frame_case("f5", 99, 5'd0,     5'd0,     5, 32'h3F, 14);

    // Half-rate pixel enable: a line spans twice the clocks, strobes stay one clock wide.
    ret1 = -1; ret2 = -1; prev_h = int'(bus.HPOS); run = 0; run_max = 0; le_n = 0;
    for (int i = 1; i <= 64; i++) begin
      bus.CE = (i % 2 == 1);
      tick();
      if (bus.HPOS == 5'd0 && prev_h != 0) begin
        if (ret1 < 0) ret1 = i;
        else if (ret2 < 0) ret2 = i;
      end
      prev_h = int'(bus.HPOS);
      if (bus.LINE_END) begin
        le_n++;
        run++;
        if (run > run_max) run_max = run;
      end else begin
        run = 0;
      end
    end
    bus.CE = 1'b1;
    check_eq("ce.line_clks", 32'(ret2 - ret1), 32'd32);
    check_eq("ce.le_cnt",    32'(le_n),        32'd2);
    check_eq("ce.le_width",  32'(run_max),     32'd1);

    guard = 0;
    while (fe_seen < 255 && guard < 40000) begin
      tick();
      guard++;
    end
    check_eq("fcnt.255", 32'(bus.FCNT), 32'd255);
    guard = 0;
    while (fe_seen < 256 && guard < 1000) begin
      tick();
      guard++;
    end
    check_eq("fcnt.wrap", 32'(bus.FCNT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
